// File: rtl/ram_bank_responder_pkg.sv
// Shared definitions for the RAM bank responder.
// - Default address/data widths for a subdivision RAM bank.
// - own_state_t: ownership FSM states (CORE -> DRAIN_C -> HOST -> DRAIN_H -> CORE).
// - credit_ok(): host command credit rule. A new host read is allowed only while the
//   reads in flight plus the buffered responses stay below two, which keeps the
//   2-entry response FIFO from ever overflowing.
package ram_bank_responder_pkg;

    localparam int RBR_ADDR_WIDTH = 11;
    localparam int RBR_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        CORE    = 2'd0,
        DRAIN_C = 2'd1,
        HOST    = 2'd2,
        DRAIN_H = 2'd3
    } own_state_t;

    function automatic logic credit_ok(input logic [1:0] fifo_count, input logic inflight);
        logic [2:0] total_s;
        total_s = {1'b0, fifo_count} + {2'b00, inflight};
        return (total_s < 3'd2);
    endfunction

endpackage

// File: rtl/ram_bank_responder_rsp_fifo2.sv
// rsp_fifo2: two-entry valid/ready FIFO for host read responses.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (empties the FIFO)
//   push_valid/push_data  write side; the caller guarantees no push while full
//   pop_valid/pop_data    head entry, both registered
//   pop_ready             head consumed when pop_valid & pop_ready
//   count                 number of buffered entries (0..2)
// ent0_r is always the head; a pop shifts ent1_r down so the output needs no mux.
module rsp_fifo2
    import ram_bank_responder_pkg::*;
#(
    parameter int WIDTH = RBR_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] ent0_r;
    logic [WIDTH-1:0] ent1_r;
    logic [1:0]       count_r;
    logic             valid_r;
    logic             push_s;
    logic             pop_s;
    logic [1:0]       count_nxt_s;

    // Qualify push/pop and work out the occupancy after this cycle.
    always_comb begin
        push_s      = push_valid && (count_r != 2'd2);
        pop_s       = pop_ready && valid_r;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage and occupancy; the head always lives in ent0_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_r  <= {WIDTH{1'b0}};
            ent1_r  <= {WIDTH{1'b0}};
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) ent0_r <= push_data;
                    else                 ent1_r <= push_data;
                end
                2'b01: ent0_r <= ent1_r;
                2'b11: begin
                    // Simultaneous push and pop: new data goes behind whatever remains.
                    if (count_r == 2'd1) begin
                        ent0_r <= push_data;
                    end else begin
                        ent0_r <= ent1_r;
                        ent1_r <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pop_valid = valid_r;
    assign pop_data  = ent0_r;
    assign count     = count_r;

endmodule

// File: rtl/ram_bank_responder.sv
// ram_bank_responder: memory-side responder for one subdivision RAM bank.
// The core port (en/a/we/di/dout) gives byte-enable writes and fixed-latency read-first reads.
// The host command port loads meshes and drains results while the bank is host-owned.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   en, a, we, di              core access enable, word address, byte write enables, write data
//   dout                       core read data (the natural name "do" is a SystemVerilog keyword)
//   host_mode                  requested owner (1 = host)
//   owner                      effective owner, registered (1 = host)
//   h_cmd_valid/ready/write/addr/data   host command channel (write = full word, else read)
//   h_rsp_valid/ready/data              host read response channel, in command order
// Ownership hands over through drain states so that neither side sees a half-finished access.
module ram_bank_responder
    import ram_bank_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = RBR_ADDR_WIDTH,
    parameter int DATA_WIDTH   = RBR_DATA_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [ADDR_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [DATA_WIDTH-1:0]   di,
    output logic [DATA_WIDTH-1:0]   dout,
    input  logic                    host_mode,
    output logic                    owner,
    input  logic                    h_cmd_valid,
    output logic                    h_cmd_ready,
    input  logic                    h_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   h_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   h_cmd_data,
    output logic                    h_rsp_valid,
    input  logic                    h_rsp_ready,
    output logic [DATA_WIDTH-1:0]   h_rsp_data
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    own_state_t            state_r;
    logic                  owner_r;
    logic                  h_cmd_ready_r;
    logic [1:0]            drain_cnt_r;
    logic [DATA_WIDTH-1:0] core_rd_r;
    logic                  h_inflight_r;
    logic [DATA_WIDTH-1:0] h_rd_data_r;

    logic                  core_acc_s;
    logic                  core_wr_s;
    logic                  h_acc_s;
    logic                  h_rd_acc_s;
    logic                  h_wr_acc_s;
    logic                  pop_s;
    logic                  fifo_valid_s;
    logic [DATA_WIDTH-1:0] fifo_data_s;
    logic [1:0]            fifo_count_s;
    logic [1:0]            fifo_count_nxt_s;

    // Access qualification for both ports and the FIFO occupancy after this cycle.
    always_comb begin
        core_acc_s = en && !owner_r;
        core_wr_s  = core_acc_s && (|we);
        h_acc_s    = h_cmd_valid && h_cmd_ready_r;
        h_rd_acc_s = h_acc_s && !h_cmd_write;
        h_wr_acc_s = h_acc_s && h_cmd_write;
        pop_s      = fifo_valid_s && h_rsp_ready;
        fifo_count_nxt_s = fifo_count_s;
        case ({h_inflight_r, pop_s})
            2'b10:   fifo_count_nxt_s = fifo_count_s + 2'd1;
            2'b01:   fifo_count_nxt_s = fifo_count_s - 2'd1;
            default: fifo_count_nxt_s = fifo_count_s;
        endcase
    end

    // Array write port: core byte lanes or a host full word; owners never overlap.
    always_ff @(posedge clk) begin
        if (core_wr_s) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) mem_r[a][i*8 +: 8] <= di[i*8 +: 8];
            end
        end else if (h_wr_acc_s) begin
            mem_r[h_cmd_addr] <= h_cmd_data;
        end
    end

    // Core read stage: every core access (write included) captures the pre-write word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rd_r <= {DATA_WIDTH{1'b0}};
        end else if (core_acc_s) begin
            core_rd_r <= mem_r[a];
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_rl2
            logic                  rd_vld_r;
            logic [DATA_WIDTH-1:0] dout_r;
            // Extra output register; dout only moves when a read reaches it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_vld_r <= 1'b0;
                    dout_r   <= {DATA_WIDTH{1'b0}};
                end else begin
                    rd_vld_r <= core_acc_s;
                    if (rd_vld_r) dout_r <= core_rd_r;
                end
            end
            assign dout = dout_r;
        end else begin : g_rl1
            assign dout = core_rd_r;
        end
    endgenerate

    // Host read stage: one cycle in flight before the word enters the response FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_inflight_r <= 1'b0;
            h_rd_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            h_inflight_r <= h_rd_acc_s;
            if (h_rd_acc_s) h_rd_data_r <= mem_r[h_cmd_addr];
        end
    end

    rsp_fifo2 #(
        .WIDTH(DATA_WIDTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (h_inflight_r),
        .push_data  (h_rd_data_r),
        .pop_valid  (fifo_valid_s),
        .pop_data   (fifo_data_s),
        .pop_ready  (h_rsp_ready),
        .count      (fifo_count_s)
    );

    // Ownership FSM with registered owner and host command ready.
    // Ready is computed from next-cycle occupancy so the registered value obeys the credit rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= CORE;
            owner_r       <= 1'b0;
            h_cmd_ready_r <= 1'b0;
            drain_cnt_r   <= 2'd0;
        end else begin
            case (state_r)
                CORE: begin
                    h_cmd_ready_r <= 1'b0;
                    drain_cnt_r   <= 2'd0;
                    if (host_mode) state_r <= DRAIN_C;
                end
                DRAIN_C: begin
                    // Let the core read pipeline empty before the host takes over.
                    if (drain_cnt_r == 2'(READ_LATENCY - 1)) begin
                        state_r       <= HOST;
                        owner_r       <= 1'b1;
                        h_cmd_ready_r <= credit_ok(fifo_count_nxt_s, h_rd_acc_s);
                    end else begin
                        drain_cnt_r   <= drain_cnt_r + 2'd1;
                        h_cmd_ready_r <= 1'b0;
                    end
                end
                HOST: begin
                    if (!host_mode) begin
                        state_r       <= DRAIN_H;
                        h_cmd_ready_r <= 1'b0;
                    end else begin
                        h_cmd_ready_r <= credit_ok(fifo_count_nxt_s, h_rd_acc_s);
                    end
                end
                DRAIN_H: begin
                    // Hand back only once every host read has been delivered and consumed.
                    h_cmd_ready_r <= 1'b0;
                    if (!h_rd_acc_s && !h_inflight_r && (fifo_count_nxt_s == 2'd0)) begin
                        state_r <= CORE;
                        owner_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= CORE;
                    owner_r       <= 1'b0;
                    h_cmd_ready_r <= 1'b0;
                    drain_cnt_r   <= 2'd0;
                end
            endcase
        end
    end

    assign owner       = owner_r;
    assign h_cmd_ready = h_cmd_ready_r;
    assign h_rsp_valid = fifo_valid_s;
    assign h_rsp_data  = fifo_data_s;

endmodule

// File: tb/tb_ram_bank_responder.sv
// Bench for ram_bank_responder: core-port vector table, ownership hand-over sequences
// and a host response scoreboard fed by a reference word model.
module tb_ram_bank_responder;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [AW-1:0] a;
    logic [3:0]    we;
    logic [DW-1:0] di;
    logic [DW-1:0] dout;
    logic          host_mode;
    logic          owner;
    logic          h_cmd_valid;
    logic          h_cmd_ready;
    logic          h_cmd_write;
    logic [AW-1:0] h_cmd_addr;
    logic [DW-1:0] h_cmd_data;
    logic          h_rsp_valid;
    logic          h_rsp_ready;
    logic [DW-1:0] h_rsp_data;

    ram_bank_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .we(we), .di(di), .dout(dout),
        .host_mode(host_mode), .owner(owner),
        .h_cmd_valid(h_cmd_valid), .h_cmd_ready(h_cmd_ready), .h_cmd_write(h_cmd_write),
        .h_cmd_addr(h_cmd_addr), .h_cmd_data(h_cmd_data),
        .h_rsp_valid(h_rsp_valid), .h_rsp_ready(h_rsp_ready), .h_rsp_data(h_rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [AW-1:0] a;
        logic [3:0]    we;
        logic [DW-1:0] di;
        logic          chk;
        logic [DW-1:0] exp;
    } core_vec_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    core_vec_t     vecs [17];
    op_t           ops_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [int];
    int            tests = 0;
    int            fails = 0;
    int            n_acc = 0;
    int            base;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One host cycle, called at a negedge: drive the head command, score pops, record accepts.
    task automatic host_step(input logic rr);
        op_t op;
        logic acc;
        logic pop;
        if (ops_q.size() > 0) begin
            op = ops_q[0];
            h_cmd_valid = 1'b1;
            h_cmd_write = op.wr;
            h_cmd_addr  = op.addr;
            h_cmd_data  = op.data;
        end else begin
            h_cmd_valid = 1'b0;
        end
        h_rsp_ready = rr;
        acc = h_cmd_valid && h_cmd_ready;
        pop = h_rsp_valid && h_rsp_ready;
        if (pop) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", h_rsp_data, 32'h0);
            else chk("rsp_data", h_rsp_data, exp_q.pop_front());
        end
        if (acc) begin
            op = ops_q.pop_front();
            n_acc++;
            if (op.wr) model[int'(op.addr)] = op.data;
            else exp_q.push_back(model[int'(op.addr)]);
        end
        @(negedge clk);
    endtask

    task automatic host_run(input int budget);
        int c;
        c = 0;
        while ((ops_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
            host_step(1'b1);
            c++;
        end
        h_cmd_valid = 1'b0;
        h_rsp_ready = 1'b0;
        chk("host_run_done", 32'(ops_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic push_op(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        op_t op;
        op.wr = wr; op.addr = addr; op.data = data;
        ops_q.push_back(op);
    endtask

    task automatic wait_owner(input logic val);
        for (int c = 0; c < 20 && owner !== val; c++) @(negedge clk);
        chk("owner_wait", {31'd0, owner}, {31'd0, val});
    endtask

    task automatic core_read_chk(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        en = 1'b1; a = addr; we = 4'h0;
        @(negedge clk);
        en = 1'b0;
        chk(name, dout, exp);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; a = '0; we = 4'h0; di = '0; host_mode = 1'b0;
        h_cmd_valid = 1'b0; h_cmd_write = 1'b0; h_cmd_addr = '0; h_cmd_data = '0; h_rsp_ready = 1'b0;

        vecs[0]  = '{1'b1, 11'd5,    4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 11'd5,    4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 11'd5,    4'h2, 32'h0000AA00, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 11'd5,    4'h0, 32'h0,        1'b1, 32'hDEADAAEF};
        vecs[4]  = '{1'b0, 11'd5,    4'h0, 32'h0,        1'b1, 32'hDEADAAEF};
        vecs[5]  = '{1'b1, 11'd9,    4'hF, 32'h12345678, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 11'd9,    4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 11'd9,    4'h0, 32'h0,        1'b1, 32'h12345678};
        vecs[8]  = '{1'b1, 11'd9,    4'h1, 32'h000000AB, 1'b1, 32'h12345678};
        vecs[9]  = '{1'b1, 11'd9,    4'h8, 32'hCD000000, 1'b1, 32'h123456AB};
        vecs[10] = '{1'b1, 11'd9,    4'h0, 32'h0,        1'b1, 32'hCD3456AB};
        vecs[11] = '{1'b1, 11'd5,    4'h0, 32'h0,        1'b1, 32'hDEADAAEF};
        vecs[12] = '{1'b1, 11'd2047, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 11'd2047, 4'h0, 32'h0,        1'b1, 32'hA5A5A5A5};
        vecs[14] = '{1'b1, 11'd0,    4'hF, 32'h0BADF00D, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 11'd0,    4'h0, 32'h0,        1'b1, 32'h0BADF00D};
        vecs[16] = '{1'b1, 11'd2047, 4'h0, 32'h0,        1'b1, 32'hA5A5A5A5};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_dout", dout, 32'h0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        chk("rst_cmd_ready", {31'd0, h_cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, h_rsp_valid}, 32'd0);
        chk("rst_rsp_data", h_rsp_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Core port vector table (one access per cycle, dout checked after the edge)
        for (int i = 0; i < 17; i++) begin
            en = vecs[i].en; a = vecs[i].a; we = vecs[i].we; di = vecs[i].di;
            @(negedge clk);
            if (vecs[i].chk) chk($sformatf("core_vec%0d", i), dout, vecs[i].exp);
        end
        en = 1'b0; we = 4'h0;
        model[5] = 32'hDEADAAEF; model[9] = 32'hCD3456AB;
        model[2047] = 32'hA5A5A5A5; model[0] = 32'h0BADF00D;

        // Hand-over to host with a core write held on the port
        host_mode = 1'b1; en = 1'b1; a = 11'd5; we = 4'hF; di = 32'h11111111;
        for (int k = 0; k <= RL; k++) begin
            @(negedge clk);
            chk($sformatf("own_up_k%0d", k), {31'd0, owner}, (k == RL) ? 32'd1 : 32'd0);
        end
        chk("host_ready_up", {31'd0, h_cmd_ready}, 32'd1);
        model[5] = 32'h11111111;
        di = 32'h22222222;
        repeat (3) @(negedge clk);
        en = 1'b0; we = 4'h0;

        // Host writes, read/write ordering on one address, and ignored core writes
        push_op(1'b1, 11'd0, 32'hA0000000); push_op(1'b1, 11'd1, 32'hA1111111);
        push_op(1'b1, 11'd2, 32'hA2222222); push_op(1'b1, 11'd3, 32'hA3333333);
        push_op(1'b1, 11'd7, 32'h77770000); push_op(1'b0, 11'd7, 32'h0);
        push_op(1'b1, 11'd7, 32'h77771111); push_op(1'b0, 11'd7, 32'h0);
        push_op(1'b0, 11'd5, 32'h0);
        host_run(60);

        // Backpressure: only two reads fit while responses are held
        for (int i = 0; i < 4; i++) push_op(1'b0, AW'(i), 32'h0);
        base = n_acc;
        repeat (6) host_step(1'b0);
        chk("bp_accepts", 32'(n_acc - base), 32'd2);
        chk("bp_cmd_ready", {31'd0, h_cmd_ready}, 32'd0);
        chk("bp_rsp_valid", {31'd0, h_rsp_valid}, 32'd1);
        host_run(40);

        // Hand back to core with two responses buffered
        push_op(1'b0, 11'd1, 32'h0); push_op(1'b0, 11'd2, 32'h0);
        repeat (4) host_step(1'b0);
        host_mode = 1'b0;
        repeat (3) host_step(1'b0);
        chk("drainh_owner_held", {31'd0, owner}, 32'd1);
        chk("drainh_cmd_ready", {31'd0, h_cmd_ready}, 32'd0);
        host_step(1'b1);
        chk("drainh_owner_one_left", {31'd0, owner}, 32'd1);
        host_step(1'b1);
        h_rsp_ready = 1'b0;
        chk("drainh_owner_back", {31'd0, owner}, 32'd0);
        chk("drainh_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // Core port works again and sees host-written data
        core_read_chk("core_after_host", 11'd0, model[0]);
        en = 1'b1; a = 11'd3; we = 4'hF; di = 32'h33330000;
        @(negedge clk);
        chk("core_rf_host_word", dout, model[3]);
        model[3] = 32'h33330000;
        core_read_chk("core_rewrite", 11'd3, model[3]);

        // Reset in the middle of a host read burst
        host_mode = 1'b1;
        wait_owner(1'b1);
        push_op(1'b0, 11'd0, 32'h0); push_op(1'b0, 11'd1, 32'h0); push_op(1'b0, 11'd2, 32'h0);
        repeat (3) host_step(1'b0);
        #2;
        rst_n = 1'b0; host_mode = 1'b0; h_cmd_valid = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, h_rsp_valid}, 32'd0);
        chk("midrst_owner", {31'd0, owner}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, h_cmd_ready}, 32'd0);
        ops_q.delete(); exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("postrst_rsp_valid", {31'd0, h_rsp_valid}, 32'd0);
        chk("postrst_owner", {31'd0, owner}, 32'd0);
        core_read_chk("postrst_array_kept", 11'd0, model[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
